// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the Wishbone instruction-SRAM loader.
package imem_pkg;

    localparam int          IMEM_AW     = 9;
    localparam int          IMEM_DW     = 32;
    localparam int          IMEM_NBYTES = 4;
    localparam logic [11:0] CTRL_OFFSET = 12'h800;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/wb_imem_loader.sv
// Wishbone classic responder for loading/reading back port 0 of the instruction
// SRAM, plus a CTRL register whose cpu_hold bit stalls the core during loading.
module wb_imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = IMEM_AW
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [IMEM_NBYTES-1:0] wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [IMEM_DW-1:0]     wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [IMEM_DW-1:0]     wbs_dat_o,
    output logic                   csb0,
    output logic                   web0,
    output logic [IMEM_NBYTES-1:0] wmask0,
    output logic [AW-1:0]          addr0,
    output logic [IMEM_DW-1:0]     din0,
    input  logic [IMEM_DW-1:0]     dout0,
    output logic                   cpu_hold
);

    state_t                 r_state;
    logic                   r_csb0;
    logic                   r_web0;
    logic [IMEM_NBYTES-1:0] r_wmask0;
    logic [AW-1:0]          r_addr0;
    logic [IMEM_DW-1:0]     r_din0;
    logic                   r_ack;
    logic [IMEM_DW-1:0]     r_dat_o;
    logic                   r_cpu_hold;

    logic w_hit;
    logic w_req;
    logic w_is_sram;
    logic w_is_ctrl;
    logic w_unused;

    // Only the top 20 address bits select this responder; anything else is left
    // unacked so another slave on the bus can answer.
    assign w_hit     = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_req     = wbs_cyc_i & wbs_stb_i & w_hit;
    assign w_is_sram = ~wbs_adr_i[11];
    assign w_is_ctrl = (wbs_adr_i[11:2] == CTRL_OFFSET[11:2]);
    assign w_unused  = ^wbs_adr_i[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state    <= IDLE;
            r_csb0     <= 1'b1;
            r_web0     <= 1'b1;
            r_wmask0   <= '0;
            r_addr0    <= '0;
            r_din0     <= '0;
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_csb0 <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_is_sram) begin
                            r_addr0  <= wbs_adr_i[AW+1:2];
                            r_din0   <= wbs_dat_i;
                            r_wmask0 <= wbs_sel_i;
                            // A write with no byte lanes still takes the SRAM path
                            // timing but never selects the macro.
                            r_csb0   <= wbs_we_i && (wbs_sel_i == '0);
                            r_web0   <= ~wbs_we_i;
                            r_state  <= ISSUE;
                        end else begin
                            if (w_is_ctrl) begin
                                if (wbs_we_i && wbs_sel_i[0])
                                    r_cpu_hold <= wbs_dat_i[0];
                                else if (!wbs_we_i)
                                    r_dat_o <= {{(IMEM_DW-1){1'b0}}, r_cpu_hold};
                            end else if (!wbs_we_i) begin
                                r_dat_o <= '0;
                            end
                            r_ack   <= 1'b1;
                            r_state <= ACK;
                        end
                    end
                end
                ISSUE: begin
                    r_web0 <= 1'b1;
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else if (!r_web0) begin
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!wbs_cyc_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_dat_o <= dout0;
                        r_ack   <= 1'b1;
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat_o;
    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign wmask0    = r_wmask0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;
    assign cpu_hold  = r_cpu_hold;

endmodule
